clk_div_prog: RTL and testbench

Programmable integer clock divider producing a 50%-duty-cycle output for any odd or even ratio from 2 to 2^DIV_W-1. It generalises the team's fixed divide-by-3 ring-style divider with four additions: a run-time ratio, a glitch-free ratio update applied at period boundaries, a clean enable/park, and a per-period tick for logic that stays in the source domain. It sits in the clock-generation area, next to the fixed dividers.

---
 rtl/clk_div_prog.sv | 140 ++++++++++++++
 tb/tb_clk_div_prog.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty integer clock divider (ratios 2..2^DIV_W-1) with ratio
// updates applied only at period starts, a clean low park on disable, and a per-period tick.
module clk_div_prog #(
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             ratio_ack,
  output logic             ratio_err,
  output logic             oclk_tick,
  output logic             oclk
);

  localparam int               HW         = DIV_W + 1;
  localparam logic [DIV_W-1:0] RATIO_INIT = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0] RATIO_MIN  = DIV_W'(2);

  logic [DIV_W-1:0] cnt_r, cnt_s;
  logic [DIV_W-1:0] ratio_r, ratio_s;
  logic [DIV_W-1:0] pend_r, pend_s;
  logic [DIV_W-1:0] req_s;
  logic [HW-1:0]    half_s;
  logic             pend_valid_r, pend_valid_s;
  logic             p_r, p_s;
  logic             n_r;
  logic             running_r, running_s;
  logic             ack_r, ack_s;
  logic             err_r, err_s;
  logic             tick_r, tick_s;
  logic             ps_s, apply_s;

  function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] r);
    if (r < RATIO_MIN) begin
      return RATIO_MIN;
    end else begin
      return r;
    end
  endfunction

  // Next-state: period-start decisions, ratio application and phase generation
  always_comb begin
    cnt_s        = cnt_r;
    ratio_s      = ratio_r;
    pend_s       = pend_r;
    pend_valid_s = pend_valid_r;
    p_s          = p_r;
    running_s    = running_r;
    ack_s        = 1'b0;
    err_s        = 1'b0;
    tick_s       = 1'b0;
    apply_s      = 1'b0;
    req_s        = pend_r;
    half_s       = ({1'b0, ratio_r} + HW'(1)) >> 1;
    // Idle counts as a period start on every edge
    ps_s         = !running_r || (cnt_r == (ratio_r - DIV_W'(1)));

    if (ps_s) begin
      // A load on the boundary edge itself wins over the older pending value
      if (load) begin
        apply_s = 1'b1;
        req_s   = div_ratio;
      end else if (pend_valid_r) begin
        apply_s = 1'b1;
        req_s   = pend_r;
      end else begin
        apply_s = 1'b0;
        req_s   = pend_r;
      end
      if (apply_s) begin
        ratio_s      = clamp_ratio(req_s);
        ack_s        = 1'b1;
        err_s        = (req_s < RATIO_MIN);
        pend_valid_s = 1'b0;
      end else begin
        ratio_s = ratio_r;
      end
      cnt_s = {DIV_W{1'b0}};
      if (en) begin
        p_s       = 1'b1;
        tick_s    = 1'b1;
        running_s = 1'b1;
      end else begin
        p_s       = 1'b0;
        tick_s    = 1'b0;
        running_s = 1'b0;
      end
    end else begin
      cnt_s = cnt_r + DIV_W'(1);
      p_s   = ({1'b0, cnt_s} < half_s);
      if (load) begin
        pend_s       = div_ratio;
        pend_valid_s = 1'b1;
      end else begin
        pend_s       = pend_r;
        pend_valid_s = pend_valid_r;
      end
    end
  end

  // Posedge state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_r        <= {DIV_W{1'b0}};
      ratio_r      <= RATIO_INIT;
      pend_r       <= {DIV_W{1'b0}};
      pend_valid_r <= 1'b0;
      p_r          <= 1'b0;
      running_r    <= 1'b0;
      ack_r        <= 1'b0;
      err_r        <= 1'b0;
      tick_r       <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      ratio_r      <= ratio_s;
      pend_r       <= pend_s;
      pend_valid_r <= pend_valid_s;
      p_r          <= p_s;
      running_r    <= running_s;
      ack_r        <= ack_s;
      err_r        <= err_s;
      tick_r       <= tick_s;
    end
  end

  // Half-cycle delayed copy of the phase; clears naturally since p is 0 in reset
  always_ff @(negedge clk) begin
    n_r <= p_r;
  end

  // The odd flag only changes when p and n are both low, so this mux cannot glitch
  assign oclk      = ratio_r[0] ? (p_r & n_r) : p_r;
  assign ratio_ack = ack_r;
  assign ratio_err = err_r;
  assign oclk_tick = tick_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized scoreboard bench for clk_div_prog: a period-level reference model
// predicts tick/ack/err events and the oclk level in every half clock cycle.
module tb_clk_div_prog;

  localparam int DIV_W    = 8;
  localparam int DIV_INIT = 3;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [DIV_W-1:0] div_ratio = '0;
  logic             ratio_ack, ratio_err, oclk_tick, oclk;

  typedef struct {
    int cyc;
    bit tick;
    bit ack;
    bit err;
  } ev_t;

  ev_t evq[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  m_n      = DIV_INIT;
  int  m_pend   = 0;
  int  m_pos    = 0;
  bit  m_pv     = 1'b0;
  bit  m_run    = 1'b0;
  bit  chk_en   = 1'b0;

  clk_div_prog #(.DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .load      (load),
    .div_ratio (div_ratio),
    .ratio_ack (ratio_ack),
    .ratio_err (ratio_err),
    .oclk_tick (oclk_tick),
    .oclk      (oclk)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected oclk in half-cycle h of a period of ratio n: high for n half-cycles,
  // starting at the period edge (even n) or half a clock later (odd n).
  function automatic bit exp_oclk(input int n, input int h, input bit run);
    if (!run) return 1'b0;
    if ((n % 2) == 1) return (h >= 1) && (h <= n);
    return h < n;
  endfunction

  // Reference model: period boundaries, pending ratio and expected events
  always @(posedge clk) begin
    int req;
    bit app;
    cyc++;
    if (!rstn) begin
      m_n    = DIV_INIT;
      m_pv   = 1'b0;
      m_run  = 1'b0;
      m_pos  = 0;
      chk_en = 1'b1;
    end else if (!m_run || m_pos == m_n - 1) begin
      app = 1'b0;
      req = 0;
      if (load) begin
        app = 1'b1;
        req = int'(div_ratio);
      end else if (m_pv) begin
        app = 1'b1;
        req = m_pend;
      end
      if (app) begin
        m_n  = (req < 2) ? 2 : req;
        m_pv = 1'b0;
      end
      m_run = en;
      m_pos = 0;
      if (app || en) evq.push_back('{cyc, en, app, app && (req < 2)});
    end else begin
      m_pos++;
      if (load) begin
        m_pend = int'(div_ratio);
        m_pv   = 1'b1;
      end
    end
  end

  // Waveform check, first half of each clock cycle
  always @(posedge clk) begin
    #2;
    if (chk_en) check("oclk_first_half", int'(oclk), int'(exp_oclk(m_n, 2 * m_pos, m_run)));
  end

  // Waveform check, second half of each clock cycle
  always @(negedge clk) begin
    #2;
    if (chk_en) check("oclk_second_half", int'(oclk), int'(exp_oclk(m_n, 2 * m_pos + 1, m_run)));
  end

  // Scoreboard monitor: pops an expected event whenever the DUT pulses tick/ack/err
  always @(negedge clk) begin
    ev_t e;
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      e = evq.pop_front();
      check("missed_event_cycle", cyc, e.cyc);
    end
    if (chk_en && (oclk_tick || ratio_ack || ratio_err)) begin
      if (evq.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e = evq.pop_front();
        check("ev_cycle", cyc, e.cyc);
        check("ev_tick", int'(oclk_tick), int'(e.tick));
        check("ev_ack", int'(ratio_ack), int'(e.ack));
        check("ev_err", int'(ratio_err), int'(e.err));
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_load(input int r);
    load      = 1'b1;
    div_ratio = 8'(r);
    @(negedge clk);
    load      = 1'b0;
  endtask

  task automatic wait_pos(input int n, input int pos);
    int k = 0;
    while (!(m_run && m_n == n && m_pos == pos) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) check("wait_timeout", 0, 1);
  endtask

  initial begin
    int sweep[4] = '{2, 5, 8, 255};
    rstn = 1'b0;
    cycles(3);
    rstn = 1'b1;
    en   = 1'b1;
    cycles(20);

    // Mid-period change from 3 to 4
    wait_pos(3, 1);
    do_load(4);
    cycles(20);

    foreach (sweep[i]) begin
      do_load(sweep[i]);
      cycles(3 * sweep[i] + 8);
    end

    // Disable mid-period at N=7, then restart
    do_load(7);
    wait_pos(7, 1);
    en = 1'b0;
    cycles(20);
    en = 1'b1;
    cycles(20);

    // Clamped request, then two loads inside one period
    do_load(1);
    cycles(10);
    do_load(5);
    cycles(12);
    wait_pos(5, 0);
    load      = 1'b1;
    div_ratio = 8'd6;
    @(negedge clk);
    div_ratio = 8'd9;
    @(negedge clk);
    load = 1'b0;
    cycles(30);

    // Reset while oclk is high at N=9 with an update pending
    wait_pos(9, 0);
    load      = 1'b1;
    div_ratio = 8'd4;
    @(negedge clk);
    load = 1'b0;
    rstn = 1'b0;
    cycles(2);
    rstn = 1'b1;
    cycles(20);

    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 11) == 0) begin
        load      = 1'b1;
        div_ratio = 8'($urandom_range(0, 12));
      end else begin
        load = 1'b0;
      end
      rstn = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    load = 1'b0;
    rstn = 1'b1;
    en   = 1'b0;
    cycles(20);
    check("queue_drained", evq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
